// File: rtl/shift_ring_counter.sv
// shift_ring_counter: ring / Johnson shift counter with run-time mode and
// direction select, parallel load, enable and illegal-state self-correction.
// Outputs q, qb, wrap and fault are all registered.
module shift_ring_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             wrap,
    output logic             fault
);

    localparam logic [WIDTH-1:0] SEED = WIDTH'(1);

    logic [WIDTH-1:0] q_inv;
    logic             ring_legal;
    logic             johnson_legal;
    logic             legal;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;
    logic             fault_nxt;

    // Legality of the current state, judged against the currently selected mode.
    // Ring: non-zero with a single bit set. Johnson: q or ~q is a run of ones
    // anchored at the LSB (covers all-0 and all-1).
    always_comb begin
        q_inv         = ~q;
        ring_legal    = (q != '0) && ((q & (q - WIDTH'(1))) == '0);
        johnson_legal = ((q & (q + WIDTH'(1))) == '0) ||
                        ((q_inv & (q_inv + WIDTH'(1))) == '0);
        legal         = mode ? johnson_legal : ring_legal;
    end

    // One shift step for the selected mode and direction.
    always_comb begin
        step_val = q;
        case ({mode, dir})
            2'b00:   step_val = {q[WIDTH-2:0], q[WIDTH-1]};
            2'b01:   step_val = {q[0], q[WIDTH-1:1]};
            2'b10:   step_val = {q[WIDTH-2:0], ~q[WIDTH-1]};
            default: step_val = {~q[0], q[WIDTH-1:1]};
        endcase
    end

    // Next-state selection: load beats enable beats hold.
    always_comb begin
        q_nxt     = q;
        wrap_nxt  = 1'b0;
        fault_nxt = 1'b0;
        if (load) begin
            q_nxt = load_val;
        end else if (en) begin
            if (legal) begin
                q_nxt    = step_val;
                wrap_nxt = (step_val == SEED);
            end else begin
                q_nxt     = SEED;
                fault_nxt = 1'b1;
            end
        end
    end

    // State and status registers; qb is kept as its own register holding ~q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q     <= SEED;
            qb    <= ~SEED;
            wrap  <= 1'b0;
            fault <= 1'b0;
        end else begin
            q     <= q_nxt;
            qb    <= ~q_nxt;
            wrap  <= wrap_nxt;
            fault <= fault_nxt;
        end
    end

endmodule

// File: doc/shift_ring_counter.md
# shift_ring_counter

Parametrised ring/Johnson shift counter with run-time mode and direction select, synchronous parallel load, enable, and self-correction of illegal states. It is a drop-in phase/sequence generator for timing-strobe and one-hot sequencing logic. It provides true (`q`) and complemented (`qb`) outputs plus registered `wrap` and `fault` status pulses.

## Interface
- `WIDTH`, default 4: counter width in bits. Legal range is 2 to 32.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `en`  input  1  step enable.
- `mode`  input  1  0 = ring (one-hot), 1 = Johnson (twisted ring).
- `dir`  input  1  0 = shift toward MSB (left), 1 = shift toward LSB (right).
- `load`  input  1  synchronous parallel load strobe.
- `load_val`  input  WIDTH  value loaded when `load`=1.
- `q`  output  WIDTH  counter state, registered.
- `qb`  output  WIDTH  bitwise complement of `q`, registered.
- `wrap`  output  1  one-cycle pulse: the last step completed a period.
- `fault`  output  1  one-cycle pulse: the last step corrected an illegal state.

## Operation
- Reset (`rst`=1, asynchronous): `q`=0…01, `qb`=1…10, `wrap`=0, `fault`=0. The value 0…01 is legal in both modes.
- Per-edge priority is `load` > `en` > hold.
  - `load`=1: `q`←`load_val` verbatim, even if illegal for the current mode. `wrap`=0, `fault`=0. `en` is ignored.
  - `en`=1, `load`=0: one step (rules below).
  - Otherwise: `q` holds, `wrap`=0, `fault`=0.
- Legal states:
  - Ring: exactly one bit set.
  - Johnson: of form 0…01…1 or 1…10…0, including all-0 and all-1.
- Step when `q` is legal for the current `mode`:
  - Ring, left: `q`←{q[W-2:0], q[W-1]}.
  - Ring, right: `q`←{q[0], q[W-1:1]}.
  - Johnson, left: `q`←{q[W-2:0], ~q[W-1]}.
  - Johnson, right: `q`←{~q[0], q[W-1:1]}.
- Step when `q` is illegal: `q`←0…01 and `fault`=1 on that edge. No shift is performed and `wrap` stays 0.
- `wrap`=1 exactly when a legal step produces `q`=0…01. Periods are WIDTH steps (ring) and 2·WIDTH steps (Johnson), in either direction.
- `mode` and `dir` are sampled on each edge. A change takes effect on the next enabled step, and legality is judged against the new `mode`. Example: ring state 0100 switched to Johnson is illegal, so that step corrects it.
- `qb` is always the exact complement of `q`. It is its own register, not derived combinationally, and must never mismatch `q`.

## Timing
- Every output changes only on the rising edge of `clk` or on assertion of `rst`.
- `q` updates one cycle after `en`/`load` is sampled. Latency is 1 cycle with no pipeline.
- `wrap` and `fault` are coincident with the `q` update that caused them. They are never asserted together.
- Reset mid-operation forces reset values immediately, regardless of `load`/`en`. The first step after `rst` deasserts starts from 0…01.
- `en` held high gives one step per cycle. There is no handshake.

## Test plan
- Ring left, WIDTH=4, `en`=1 from reset: `q` = 0010, 0100, 1000, 0001. `wrap`=1 only on the 0001 step, then repeats every 4 cycles. `qb` = ~`q` on every cycle.
- Johnson left, WIDTH=4, from reset: `q` = 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001. `wrap` pulses on the 8th step. Johnson right from 0001: `q` = 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001 with `wrap`.
- Load 0110 in ring mode, then `en`=1: `q`=0110 with `fault`=0 after the load, then `q`=0001 with `fault`=1 and `wrap`=0. Load 0101 in Johnson mode gives the same correction.
- `load` and `en` together with `load_val`=0100 gives `q`=0100 with no step. `en`=0 for 5 cycles holds `q`, with `wrap`=`fault`=0.
- Ring 0100, then switch `mode`=1 with `en`=1: `fault`=1 and `q`=0001. Next step gives 0011.
- Assert `rst` asynchronously between edges while in Johnson state 1110: `q`=0001 and `qb`=1110 immediately, `wrap`/`fault`=0. After release, stepping resumes from 0001.
